wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_rr_arbiter.sv | 175 +++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter that shares one Wishbone classic device port among
// NUM_CTRL controllers. A grant is held for the whole cyc. A wait counter
// aborts a bus cycle that the device never acknowledges.
module wb_rr_arbiter #(
  parameter int NUM_CTRL   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_CTRL-1:0]            m_cyc_i,
  input  logic [NUM_CTRL-1:0]            m_stb_i,
  input  logic [NUM_CTRL-1:0]            m_we_i,
  input  logic [NUM_CTRL*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]          m_dat_o,
  output logic [NUM_CTRL-1:0]            m_ack_o,
  output logic [NUM_CTRL-1:0]            m_err_o,
  output logic                           s_cyc_o,
  output logic                           s_stb_o,
  output logic                           s_we_o,
  output logic [DATA_WIDTH-1:0]          s_dat_o,
  input  logic [DATA_WIDTH-1:0]          s_dat_i,
  input  logic                           s_ack_i,
  output logic [$clog2(NUM_CTRL)-1:0]    grant_o,
  output logic                           busy_o
);

  localparam int GW = $clog2(NUM_CTRL);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [GW-1:0]   winner;
  logic            g_cyc, g_stb, g_we;
  logic [DATA_WIDTH-1:0] g_dat;
  logic [DATA_WIDTH-1:0] dat_arr [NUM_CTRL];
  logic            in_busy;
  logic            timeout_hit;

  genvar gi;

  // Unpack the flat write-data bus into one word per controller.
  generate
    for (gi = 0; gi < NUM_CTRL; gi++) begin : g_dat_unpack
      assign dat_arr[gi] = m_dat_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // The granted controller's signals, selected by the registered grant.
  assign g_cyc   = m_cyc_i[grant_q];
  assign g_stb   = m_stb_i[grant_q];
  assign g_we    = m_we_i[grant_q];
  assign g_dat   = dat_arr[grant_q];
  assign in_busy = (state_q == BUSY);

  // The device has had TIMEOUT wait cycles and still does not ack. An ack in this
  // same cycle takes precedence, so the abort is suppressed.
  assign timeout_hit = in_busy && g_stb && !s_ack_i && (cnt_q == CW'(TIMEOUT));

  // Round-robin pick: the first requester scanning upward from last_grant+1.
  // The loop runs downward, so the nearest candidate is written last and wins.
  always_comb begin
    logic [GW:0] cand;
    winner = '0;
    cand   = '0;
    for (int i = NUM_CTRL; i >= 1; i--) begin
      cand = {1'b0, last_grant_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(NUM_CTRL)) begin
        cand = cand - (GW+1)'(NUM_CTRL);
      end
      if (m_cyc_i[cand[GW-1:0]]) begin
        winner = cand[GW-1:0];
      end
    end
  end

  // Next-state, grant and wait-counter logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = '0;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d      = BUSY;
          grant_d      = winner;
          last_grant_d = winner;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = ABORT;
        end else if (g_stb && !s_ack_i) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ABORT: begin
        if (!g_cyc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset gives controller 0 first priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_CTRL - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // Device-side outputs pass straight through from the owner, but only while BUSY.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_dat_o = '0;
    if (in_busy) begin
      s_cyc_o = g_cyc;
      s_stb_o = g_stb;
      s_we_o  = g_we;
      s_dat_o = g_dat;
    end
  end

  // Per-controller ack and err. Only the owner can see either one.
  generate
    for (gi = 0; gi < NUM_CTRL; gi++) begin : g_resp
      assign m_ack_o[gi] = in_busy && (grant_q == GW'(gi)) && s_ack_i;
      assign m_err_o[gi] = timeout_hit && (grant_q == GW'(gi));
    end
  endgenerate

  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

`ifndef SYNTHESIS
  a_resp_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(m_ack_o | m_err_o));
  a_cyc_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    s_cyc_o |-> busy_o);
  a_grant_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (busy_o && $past(busy_o)) |-> $stable(grant_o));
  c_abort: cover property (@(posedge clk_i) disable iff (!rst_ni) state_q == ABORT);
  generate
    for (gi = 0; gi < NUM_CTRL; gi++) begin : g_cov
      c_grant: cover property (@(posedge clk_i) disable iff (!rst_ni)
        busy_o && (grant_o == GW'(gi)));
    end
  endgenerate
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter. Stimulus tasks push the expected ack or err
// response. A separate monitor pops an entry and compares it whenever the DUT
// raises any m_ack_o or m_err_o bit.
module tb_wb_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*DW-1:0] m_dat;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [DW-1:0]   s_dat_o, s_dat_i;
  logic            s_ack_i;
  logic [1:0]      grant_o;
  logic            busy_o;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.NUM_CTRL(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_dat_i(m_dat),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  typedef struct packed {
    logic [N-1:0]  ack;
    logic [N-1:0]  err;
    logic [1:0]    grant;
    logic [DW-1:0] mdat;
    logic [DW-1:0] sdat;
    logic          swe;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic we, input logic [DW-1:0] d);
    m_cyc[k] = 1'b1;
    m_stb[k] = 1'b1;
    m_we[k]  = we;
    m_dat[k*DW +: DW] = d;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_s_cyc"}, 32'(s_cyc_o), 32'd0);
    check({tag, "_s_stb"}, 32'(s_stb_o), 32'd0);
    check({tag, "_s_we"},  32'(s_we_o),  32'd0);
    check({tag, "_s_dat"}, 32'(s_dat_o), 32'd0);
    check({tag, "_ack"},   32'(m_ack_o), 32'd0);
    check({tag, "_err"},   32'(m_err_o), 32'd0);
    check({tag, "_busy"},  32'(busy_o),  32'd0);
    check({tag, "_grant"}, 32'(grant_o), 32'd0);
  endtask

  // Wait (bounded) for the device port to open. Then check the latency and the owner.
  task automatic wait_busy(input int k, input int exp_wait);
    int c;
    c = 0;
    @(negedge clk);
    while (!(busy_o && s_cyc_o) && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("grant_latency", 32'(c), 32'(exp_wait));
    check("grant_idx", 32'(grant_o), 32'(k));
  endtask

  // One acknowledged transfer for controller k. The device acks after 'delay' wait cycles.
  task automatic serve(input int k, input int exp_wait, input int delay, input logic [DW-1:0] rdat);
    exp_t e;
    e.ack   = 4'(1 << k);
    e.err   = '0;
    e.grant = 2'(k);
    e.mdat  = rdat;
    e.sdat  = m_dat[k*DW +: DW];
    e.swe   = m_we[k];
    exp_q.push_back(e);
    wait_busy(k, exp_wait);
    repeat (delay) step();
    s_ack_i = 1'b1;
    s_dat_i = rdat;
    step();
    s_ack_i  = 1'b0;
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
    @(negedge clk);
    check("release_s_cyc", 32'(s_cyc_o), 32'd0);
    check("release_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("idle_gap", 32'(busy_o), 32'd0);
  endtask

  // Controller k is never acked. Expect err in stb cycle TO+1, then ABORT until cyc drops.
  task automatic timeout_xfer(input int k, input int exp_wait);
    exp_t e;
    e.ack   = '0;
    e.err   = 4'(1 << k);
    e.grant = 2'(k);
    e.mdat  = s_dat_i;
    e.sdat  = m_dat[k*DW +: DW];
    e.swe   = m_we[k];
    exp_q.push_back(e);
    wait_busy(k, exp_wait);
    repeat (TO - 1) @(negedge clk);
    check("err_early", 32'(m_err_o), 32'd0);
    @(negedge clk);
    check("err_pulse", 32'(m_err_o), 32'(1 << k));
    @(negedge clk);
    check("abort_s_cyc", 32'(s_cyc_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd1);
    repeat (3) @(negedge clk);
    check("abort_hold_busy", 32'(busy_o), 32'd1);
    check("abort_hold_err", 32'(m_err_o), 32'd0);
    step();
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
    @(negedge clk);
    check("abort_still", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("abort_exit", 32'(busy_o), 32'd0);
  endtask

  // Monitor: each ack or err pulse is matched against the next expected response.
  initial begin
    forever begin
      @(negedge clk);
      if ((m_ack_o | m_err_o) != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'(m_ack_o | m_err_o), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("mon_ack",   32'(m_ack_o), 32'(mon_e.ack));
          check("mon_err",   32'(m_err_o), 32'(mon_e.err));
          check("mon_grant", 32'(grant_o), 32'(mon_e.grant));
          check("mon_m_dat", 32'(m_dat_o), 32'(mon_e.mdat));
          check("mon_s_dat", 32'(s_dat_o), 32'(mon_e.sdat));
          check("mon_s_we",  32'(s_we_o),  32'(mon_e.swe));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni  = 1'b0;
    m_cyc   = '0;
    m_stb   = '0;
    m_we    = '0;
    m_dat   = '0;
    s_ack_i = 1'b0;
    s_dat_i = '0;
    repeat (2) @(negedge clk);
    chk_zero("in_reset");
    step();
    rst_ni = 1'b1;
    @(negedge clk);
    chk_zero("after_reset");

    // Single request from controller 0. The device acks one cycle later.
    step();
    set_req(0, 1'b1, 8'hA5);
    serve(0, 1, 1, 8'h3C);

    // Round robin starting from a fresh reset. The grant order is 0,1,2,3,0.
    step(); rst_ni = 1'b0;
    step(); rst_ni = 1'b1;
    step();
    set_req(0, 1'b1, 8'h10);
    set_req(1, 1'b0, 8'h21);
    set_req(2, 1'b1, 8'h32);
    set_req(3, 1'b0, 8'h43);
    serve(0, 1, 1, 8'h01);
    serve(1, 0, 2, 8'h02);
    step();
    set_req(0, 1'b0, 8'h54);
    serve(2, 0, 1, 8'h03);
    serve(3, 0, 1, 8'h04);
    serve(0, 0, 1, 8'h05);

    // Lock: controller 0 asks while 2 owns the port. It must wait for 2 to release.
    step();
    set_req(2, 1'b1, 8'h66);
    step();
    set_req(0, 1'b1, 8'h77);
    serve(2, 0, 3, 8'h06);
    serve(0, 0, 1, 8'h07);

    // Timeout with no device ack.
    step();
    set_req(1, 1'b0, 8'h88);
    timeout_xfer(1, 1);

    // Ack arrives exactly in the timeout cycle. The ack wins.
    step();
    set_req(3, 1'b1, 8'h99);
    serve(3, 1, TO, 8'h08);

    // Reset in the middle of a transfer by controller 2 while 1 and 3 wait.
    step();
    set_req(2, 1'b1, 8'hC2);
    step();
    set_req(1, 1'b0, 8'hC1);
    set_req(3, 1'b0, 8'hC3);
    step();
    rst_ni  = 1'b0;
    s_ack_i = 1'b1;
    set_req(0, 1'b1, 8'hC0);
    #1;
    check("midrst_s_cyc", 32'(s_cyc_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_ack", 32'(m_ack_o), 32'd0);
    check("midrst_grant", 32'(grant_o), 32'd0);
    @(negedge clk);
    check("midrst_ack_hold", 32'(m_ack_o), 32'd0);
    check("midrst_err_hold", 32'(m_err_o), 32'd0);
    step();
    rst_ni  = 1'b1;
    s_ack_i = 1'b0;
    serve(0, 1, 1, 8'h09);
    serve(1, 0, 1, 8'h0A);
    serve(2, 0, 1, 8'h0B);
    serve(3, 0, 1, 8'h0C);

    step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
